rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 data mux among four requesters and presents the selected word on a registered valid/ready output port. It decides which source is selected, drives the mux select encoding, and holds the choice until the downstream consumer accepts the word. An optional per-requester lock allows bounded back-to-back bursts. It sits between the four source blocks and a single shared consumer.

---
 rtl/rr_mux_arbiter_if.sv | 36 +++
 rtl/rr_mux_arbiter.sv | 169 ++++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter_if
// Description : Request, data and valid/ready bus between four sources, the
//               round-robin mux arbiter and the shared downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_mux_arbiter_if #(
    parameter int DW = 2
);
    logic [3:0]    req;
    logic [3:0]    lock;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] d3;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    grant;
    logic [1:0]    sel;
    logic          busy;

    // Sources and consumer side: drives requests/data/ready, observes the port
    modport master (
        output req, lock, d0, d1, d2, d3, out_ready,
        input  out_valid, out_data, grant, sel, busy
    );

    // Arbiter side
    modport slave (
        input  req, lock, d0, d1, d2, d3, out_ready,
        output out_valid, out_data, grant, sel, busy
    );
endinterface
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter
// Description : Round-robin arbiter for a shared 4:1 data mux. Registers the
//               winner's word on a valid/ready port, holds it under
//               backpressure, and supports bounded lock bursts per requester.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
    parameter int DW        = 2,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux_arbiter_if.slave  bus
);

    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t        r_state;
    logic [1:0]    r_ptr;
    logic [3:0]    r_cnt;
    logic [1:0]    r_win;
    logic [3:0]    r_grant;
    logic [1:0]    r_sel;
    logic [DW-1:0] r_data;
    logic          r_valid;

    state_t        w_state;
    logic [1:0]    w_ptr;
    logic [3:0]    w_cnt;
    logic [1:0]    w_win;
    logic [3:0]    w_grant;
    logic [1:0]    w_sel;
    logic [DW-1:0] w_data;
    logic          w_valid;

    logic [DW-1:0] w_src [4];
    logic [3:0]    w_arb_req;
    logic [1:0]    w_arb_ptr;
    logic [2:0]    w_arb;
    logic          w_found;
    logic [1:0]    w_pick;

    // First asserted request scanning upward from p (mod 4); returns {found, index}.
    // The scan runs from the farthest offset down so the nearest hit is kept last.
    function automatic logic [2:0] f_arb(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Source words indexed by requester number
    always_comb begin
        w_src[0] = bus.d0;
        w_src[1] = bus.d1;
        w_src[2] = bus.d2;
        w_src[3] = bus.d3;
    end

    // Arbitration inputs: in XFER this is the rotation case, so the pointer
    // moves past the current owner and its request is masked out.
    always_comb begin
        w_arb_req = bus.req;
        w_arb_ptr = r_ptr;
        if (r_state == ST_XFER) begin
            w_arb_req = bus.req & ~(4'b0001 << r_win);
            w_arb_ptr = r_win + 2'd1;
        end
        w_arb   = f_arb(w_arb_req, w_arb_ptr);
        w_found = w_arb[2];
        w_pick  = w_arb[1:0];
    end

    // Next-state and registered-output decisions
    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_cnt   = r_cnt;
        w_win   = r_win;
        w_grant = r_grant;
        w_sel   = r_sel;
        w_data  = r_data;
        w_valid = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state = ST_XFER;
                    w_win   = w_pick;
                    w_grant = 4'b0001 << w_pick;
                    w_sel   = ~w_pick;
                    w_data  = w_src[w_pick];
                    w_valid = 1'b1;
                    w_cnt   = 4'd1;
                end
            end
            ST_XFER: begin
                // out_valid is always high in XFER, so out_ready alone marks the handshake
                if (bus.out_ready) begin
                    if (bus.lock[r_win] && bus.req[r_win] && (r_cnt < c_max_burst)) begin
                        w_data = w_src[r_win];
                        w_cnt  = r_cnt + 4'd1;
                    end else begin
                        w_ptr = r_win + 2'd1;
                        if (w_found) begin
                            w_win   = w_pick;
                            w_grant = 4'b0001 << w_pick;
                            w_sel   = ~w_pick;
                            w_data  = w_src[w_pick];
                            w_cnt   = 4'd1;
                        end else begin
                            w_state = ST_IDLE;
                            w_valid = 1'b0;
                            w_grant = 4'b0000;
                        end
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_valid = 1'b0;
                w_grant = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight beat at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= 4'd0;
            r_win   <= 2'd0;
            r_grant <= 4'b0000;
            r_sel   <= 2'b11;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_cnt   <= w_cnt;
            r_win   <= w_win;
            r_grant <= w_grant;
            r_sel   <= w_sel;
            r_data  <= w_data;
            r_valid <= w_valid;
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.grant     = r_grant;
    assign bus.sel       = r_sel;
    assign bus.busy      = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Directed self-checking bench for rr_mux_arbiter with a
//               scoreboard of expected beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

    localparam int DW = 2;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    typedef struct packed {
        logic [3:0]    g;
        logic [1:0]    s;
        logic [DW-1:0] d;
    } beat_t;

    beat_t sb[$];

    rr_mux_arbiter_if #(.DW(DW)) bus ();

    rr_mux_arbiter #(.DW(DW), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] s, input logic [DW-1:0] d);
        beat_t b;
        b.g = g;
        b.s = s;
        b.d = d;
        sb.push_back(b);
    endtask

    task automatic pop_chk(input string tag);
        beat_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s scoreboard empty observed_grant=%0h expected=beat", tag, bus.grant);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 8'(bus.out_valid), 8'd1);
            chk({tag, "_busy"},  8'(bus.busy),      8'd1);
            chk({tag, "_grant"}, 8'(bus.grant),     8'(e.g));
            chk({tag, "_sel"},   8'(bus.sel),       8'(e.s));
            chk({tag, "_data"},  8'(bus.out_data),  8'(e.d));
        end
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] exp_sel);
        chk({tag, "_valid"}, 8'(bus.out_valid), 8'd0);
        chk({tag, "_busy"},  8'(bus.busy),      8'd0);
        chk({tag, "_grant"}, 8'(bus.grant),     8'd0);
        chk({tag, "_sel"},   8'(bus.sel),       8'(exp_sel));
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.req       = 4'b0000;
        bus.lock      = 4'b0000;
        bus.d0        = '0;
        bus.d1        = '0;
        bus.d2        = '0;
        bus.d3        = '0;
        bus.out_ready = 1'b0;

        // 1. Reset values and a single request
        @(negedge clk);
        @(negedge clk);
        chk_idle("rst", 2'b11);
        chk("rst_data", 8'(bus.out_data), 8'd0);
        rst_n = 1'b1;
        tick();
        chk_idle("idle_after_rst", 2'b11);

        bus.req       = 4'b0100;
        bus.d2        = 2'b10;
        bus.out_ready = 1'b1;
        push(4'b0100, 2'b01, 2'b10);
        tick();
        pop_chk("single");
        bus.req = 4'b0000;
        tick();
        chk_idle("single_done", 2'b01);

        // ptr should now be 3: with req 0 and 3 both high, 3 wins
        bus.req = 4'b1001;
        bus.d3  = 2'b01;
        bus.d0  = 2'b11;
        push(4'b1000, 2'b00, 2'b01);
        tick();
        pop_chk("ptr3");
        bus.req = 4'b0000;
        tick();
        chk_idle("ptr3_done", 2'b00);

        // 2. Round-robin fairness, back-to-back beats
        bus.d0  = 2'd0;
        bus.d1  = 2'd1;
        bus.d2  = 2'd2;
        bus.d3  = 2'd3;
        bus.req = 4'b1111;
        push(4'b0001, 2'b11, 2'd0);
        push(4'b0010, 2'b10, 2'd1);
        push(4'b0100, 2'b01, 2'd2);
        push(4'b1000, 2'b00, 2'd3);
        push(4'b0001, 2'b11, 2'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            pop_chk("rr");
        end
        bus.req = 4'b0000;
        tick();
        chk_idle("rr_done", 2'b11);

        // 3. Backpressure: requester 1 held while its source toggles
        bus.out_ready = 1'b0;
        bus.req       = 4'b0010;
        bus.d1        = 2'b01;
        push(4'b0010, 2'b10, 2'b01);
        tick();
        pop_chk("bp_grant");
        for (int i = 0; i < 5; i++) begin
            bus.d1 = bus.d1 ^ 2'b11;
            tick();
            chk("bp_hold_data",  8'(bus.out_data),  8'h01);
            chk("bp_hold_grant", 8'(bus.grant),     8'h02);
            chk("bp_hold_sel",   8'(bus.sel),       8'h02);
            chk("bp_hold_valid", 8'(bus.out_valid), 8'h01);
        end
        bus.out_ready = 1'b1;
        tick();
        chk_idle("bp_done", 2'b10);
        bus.req = 4'b0000;

        // 4. Lock burst limited to four beats, then rotation and return
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        for (int b = 0; b < 4; b++) begin
            bus.d0 = 2'(b);
            push(4'b0001, 2'b11, 2'(b));
            tick();
            pop_chk("lock_burst");
        end
        bus.d1 = 2'b01;
        push(4'b0010, 2'b10, 2'b01);
        tick();
        pop_chk("lock_rotate");
        bus.d0 = 2'b11;
        push(4'b0001, 2'b11, 2'b11);
        tick();
        pop_chk("lock_return");
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;
        tick();
        chk_idle("lock_done", 2'b11);

        // 5. Finished requester is masked even though req is still high
        bus.req = 4'b1000;
        bus.d3  = 2'b10;
        push(4'b1000, 2'b00, 2'b10);
        tick();
        pop_chk("mask_grant");
        tick();
        chk_idle("mask_no_rebeat", 2'b00);
        bus.req = 4'b0000;

        // 6. Asynchronous reset during a stalled beat
        bus.out_ready = 1'b0;
        bus.req       = 4'b0100;
        bus.d2        = 2'b01;
        push(4'b0100, 2'b01, 2'b01);
        tick();
        pop_chk("rst_mid_grant");
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rst_async", 2'b11);
        chk("rst_async_data", 8'(bus.out_data), 8'd0);
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        bus.d0        = 2'b10;
        rst_n         = 1'b1;
        push(4'b0001, 2'b11, 2'b10);
        @(posedge clk);
        @(negedge clk);
        pop_chk("rst_restart");
        bus.req = 4'b0000;
        tick();
        chk_idle("end_idle", 2'b11);

        chk("sb_drained", 8'(sb.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
